// File: rtl/pc_unit_ras_pkg.sv
// Shared types and helpers for the fetch-stage PC unit.
// Next-PC source select, instruction size, pseudo-direct jump target.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_BR,
    PC_J,
    PC_JR,
    PC_RET,
    PC_HOLD
  } pc_sel_e;

  localparam int INSTR_BYTES = 4;

  // Worked at 64 bits so one helper serves both PC widths.
  function automatic logic [63:0] jump_target(
    input logic [63:0] pc_plus_4,
    input logic [25:0] jump_imm
  );
    return {pc_plus_4[63:28], jump_imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_unit_ras_ras.sv
// Circular return-address stack for the PC unit.
// Overflow overwrites the oldest entry; underflow leaves state untouched.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            overflow,
  output logic            underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_top_idx;

  assign w_top_idx = r_ptr - 1'b1;
  assign top       = r_mem[w_top_idx];
  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(RAS_DEPTH));
  assign overflow  = push & full;
  assign underflow = pop & empty;

  // Pointer and occupancy; ptr wraps naturally at a power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + 1'b1;
      if (!full) r_count <= r_count + 1'b1;
    end else if (pop && !empty) begin
      r_ptr   <= r_ptr - 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  // Entry storage, written at ptr on every push.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with return-address stack.
// Optional halt-on-address feature: define PC_HALT_EN.
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4,
  parameter logic [31:0]     HALT_PC   = 32'h14
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_addr,
  input  logic            jump,
  input  logic [25:0]     jump_imm,
  input  logic            jump_link,
  input  logic            jump_reg,
  input  logic            ret,
  input  logic [XLEN-1:0] jr_addr,
  output logic [XLEN-1:0] cur_pc,
  output logic [XLEN-1:0] pc_plus_4,
  output logic [XLEN-1:0] next_pc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err,
  output logic            pc_halted
);

  logic [XLEN-1:0] r_pc;
  logic            r_err;
  logic            w_halted;
  logic            w_hold;
  logic            w_ret;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_top;
  logic [XLEN-1:0] w_jt;
  logic            w_ovf;
  logic            w_unf;
  pc_sel_e         w_sel;

  assign w_hold    = stall | w_halted;
  assign w_ret     = ret & jump_reg;
  assign w_pop     = w_ret & ~w_hold;
  assign w_push    = jump & jump_link & ~w_ret & ~w_hold;
  assign pc_plus_4 = r_pc + XLEN'(INSTR_BYTES);
  assign w_jt      = XLEN'(jump_target(64'(pc_plus_4), jump_imm));
  assign cur_pc    = r_pc;
  assign ras_err   = r_err;
  assign pc_halted = w_halted;

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (pc_plus_4),
    .top       (w_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (w_ovf),
    .underflow (w_unf)
  );

  // Priority encode the next-PC source.
  always_comb begin
    w_sel = PC_SEQ;
    if (w_hold)            w_sel = PC_HOLD;
    else if (w_ret)        w_sel = PC_RET;
    else if (jump_reg)     w_sel = PC_JR;
    else if (jump)         w_sel = PC_J;
    else if (branch_taken) w_sel = PC_BR;
  end

  // Next-PC mux; an empty-stack return falls back to jr_addr.
  always_comb begin
    next_pc = pc_plus_4;
    unique case (w_sel)
      PC_HOLD: next_pc = r_pc;
      PC_RET:  next_pc = ras_empty ? jr_addr : w_top;
      PC_JR:   next_pc = jr_addr;
      PC_J:    next_pc = w_jt;
      PC_BR:   next_pc = branch_addr;
      default: next_pc = pc_plus_4;
    endcase
  end

  // Current PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= RESET_VEC;
    else        r_pc <= next_pc;
  end

  // Sticky stack error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_err <= 1'b0;
    else if (w_ovf || w_unf) r_err <= 1'b1;
  end

`ifdef PC_HALT_EN
  logic r_halted;
  assign w_halted = r_halted;

  // Halt once fetch is steered to the halt address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_halted <= 1'b0;
    else if (!w_hold && next_pc == XLEN'(HALT_PC))
      r_halted <= 1'b1;
  end
`else
  assign w_halted = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed scoreboard bench for pc_unit_ras.
// Expectations are queued with stimulus and drained after each edge.
module tb_pc_unit_ras;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        jump;
  logic [25:0] jump_imm;
  logic        jump_link;
  logic        jump_reg;
  logic        ret;
  logic [31:0] jr_addr;
  logic [31:0] cur_pc;
  logic [31:0] pc_plus_4;
  logic [31:0] next_pc;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;
  logic        pc_halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  localparam int K_PC  = 0;
  localparam int K_EMP = 1;
  localparam int K_FUL = 2;
  localparam int K_ERR = 3;
  localparam int K_HLT = 4;
  localparam int K_NXT = 5;
  localparam int K_P4  = 6;

  pc_unit_ras dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .jump         (jump),
    .jump_imm     (jump_imm),
    .jump_link    (jump_link),
    .jump_reg     (jump_reg),
    .ret          (ret),
    .jr_addr      (jr_addr),
    .cur_pc       (cur_pc),
    .pc_plus_4    (pc_plus_4),
    .next_pc      (next_pc),
    .ras_empty    (ras_empty),
    .ras_full     (ras_full),
    .ras_err      (ras_err),
    .pc_halted    (pc_halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(int k);
    case (k)
      K_PC:    return cur_pc;
      K_EMP:   return {31'b0, ras_empty};
      K_FUL:   return {31'b0, ras_full};
      K_ERR:   return {31'b0, ras_err};
      K_HLT:   return {31'b0, pc_halted};
      K_NXT:   return next_pc;
      default: return pc_plus_4;
    endcase
  endfunction

  task automatic want(string t, int k, logic [31:0] e);
    exp_t x;
    x.tag  = t;
    x.kind = k;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.kind);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic idle();
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    jump         = 1'b0;
    jump_imm     = '0;
    jump_link    = 1'b0;
    jump_reg     = 1'b0;
    ret          = 1'b0;
    jr_addr      = '0;
  endtask

  task automatic jal(logic [31:0] tgt);
    idle();
    jump      = 1'b1;
    jump_link = 1'b1;
    jump_imm  = tgt[27:2];
  endtask

  task automatic do_ret(logic [31:0] jr);
    idle();
    jump_reg = 1'b1;
    ret      = 1'b1;
    jr_addr  = jr;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    want("rst_pc", K_PC, 32'h0);
    want("rst_emp", K_EMP, 1);
    want("rst_ful", K_FUL, 0);
    want("rst_err", K_ERR, 0);
    want("rst_hlt", K_HLT, 0);
    drain();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] links [5];
  logic [31:0] tgts  [5];

  initial begin
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    reset_dut();

    // Sequential fetch after reset
    want("p4_rst", K_P4, 32'h4);
    drain();
    want("seq1", K_PC, 32'h4);
    cyc();
    want("seq2", K_PC, 32'h8);
    cyc();
    want("seq3", K_PC, 32'hC);
    cyc();
    want("seq4", K_PC, 32'h10);
    cyc();

    // JAL from 0x10 to 0x100
    jal(32'h100);
    #1;
    want("jal_nxt", K_NXT, 32'h100);
    drain();
    want("jal_pc", K_PC, 32'h100);
    want("jal_emp", K_EMP, 0);
    cyc();

    // Return pops 0x14, ignoring jr_addr
    do_ret(32'hDEAD);
    #1;
    want("ret_nxt", K_NXT, 32'h14);
    drain();
    want("ret_pc", K_PC, 32'h14);
    want("ret_emp", K_EMP, 1);
    want("ret_err", K_ERR, 0);
    cyc();

    // Five nested calls overflow a 4-deep stack
    tgts[0] = 32'h1000;
    tgts[1] = 32'h2000;
    tgts[2] = 32'h3000;
    tgts[3] = 32'h4000;
    tgts[4] = 32'h5000;
    links[0] = 32'h18;
    for (int i = 1; i < 5; i++) links[i] = tgts[i-1] + 4;
    for (int i = 0; i < 5; i++) begin
      jal(tgts[i]);
      want($sformatf("call%0d_pc", i), K_PC, tgts[i]);
      want($sformatf("call%0d_ful", i), K_FUL, (i >= 3) ? 1 : 0);
      want($sformatf("call%0d_err", i), K_ERR, (i == 4) ? 1 : 0);
      cyc();
    end

    // Unwind returns 5th..2nd links, oldest was overwritten
    for (int i = 4; i >= 1; i--) begin
      do_ret(32'hBAD0);
      want($sformatf("unw%0d_pc", i), K_PC, links[i]);
      want($sformatf("unw%0d_emp", i), K_EMP, (i == 1) ? 1 : 0);
      cyc();
    end

    // Underflow after a fresh reset
    idle();
    reset_dut();
    do_ret(32'h200);
    want("unf_pc", K_PC, 32'h200);
    want("unf_err", K_ERR, 1);
    want("unf_emp", K_EMP, 1);
    cyc();

    // Stall beats branch and link
    idle();
    stall        = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h300;
    jump         = 1'b1;
    jump_link    = 1'b1;
    jump_imm     = 26'h100;
    want("stl_pc", K_PC, 32'h200);
    want("stl_emp", K_EMP, 1);
    cyc();

    // Branch taken when stall drops
    idle();
    branch_taken = 1'b1;
    branch_addr  = 32'hF000_0000;
    want("br_pc", K_PC, 32'hF000_0000);
    cyc();

    // Jump keeps the upper nibble of pc_plus_4
    idle();
    jump     = 1'b1;
    jump_imm = 26'h10;
    want("jhi_pc", K_PC, 32'hF000_0040);
    want("jhi_emp", K_EMP, 1);
    cyc();

    // JR without ret leaves the stack alone
    idle();
    jump_reg = 1'b1;
    jr_addr  = 32'hFFFF_FFFC;
    want("jr_pc", K_PC, 32'hFFFF_FFFC);
    cyc();

    // Sequential wrap at the top of the address space
    idle();
    want("wrap_p4", K_P4, 32'h0);
    drain();
    want("wrap_pc", K_PC, 32'h0);
    cyc();

`ifdef PC_HALT_EN
    reset_dut();
    idle();
    branch_taken = 1'b1;
    branch_addr  = 32'h14;
    want("hlt_pc", K_PC, 32'h14);
    want("hlt_flag", K_HLT, 1);
    cyc();
    branch_addr = 32'h800;
    want("hlt_hold", K_PC, 32'h14);
    cyc();
    idle();
    reset_dut();
    want("hlt_clr", K_HLT, 0);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
